// File: rtl/fpnew_pkg.sv
// fpnew_pkg: shared helpers for FPU request scheduling.
// Index widths and credit counter update codes.
package fpnew_pkg;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_out);
    return $clog2(max_out + 1);
  endfunction

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_INC,
    CNT_DEC,
    CNT_CLR
  } cnt_op_e;

endpackage

// File: rtl/fpnew_sched_rr_arb.sv
// fpnew_sched_rr_arb: lockable round-robin priority picker.
// Lock holds the grant while the FPU stalls a presented request.
module fpnew_sched_rr_arb
  import fpnew_pkg::*;
#(
  parameter int unsigned NumReq = 4,
  localparam int unsigned IdWidth = id_width(NumReq)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic [NumReq-1:0]  req_i,
  input  logic               ready_i,
  output logic               valid_o,
  output logic [NumReq-1:0]  gnt_o,
  output logic [IdWidth-1:0] id_o
);

  logic [IdWidth-1:0] rr_ptr_q;
  logic [IdWidth-1:0] lock_id_q;
  logic               lock_q;
  logic [IdWidth-1:0] scan_id;
  logic               scan_valid;
  logic [IdWidth-1:0] nxt_ptr;
  logic [IdWidth-1:0] cand [NumReq];

  // Candidate order: rr_ptr, rr_ptr+1, ... wrapping at NumReq
  always_comb begin
    for (int unsigned off = 0; off < NumReq; off++) begin
      cand[off] = IdWidth'((32'(rr_ptr_q) + off) % NumReq);
    end
  end

  // First requesting candidate in rotation order wins
  always_comb begin
    scan_valid = 1'b0;
    scan_id    = rr_ptr_q;
    for (int unsigned off = 0; off < NumReq; off++) begin
      if (!scan_valid && req_i[cand[off]]) begin
        scan_valid = 1'b1;
        scan_id    = cand[off];
      end
    end
  end

  // A held grant overrides the rotation scan
  always_comb begin
    valid_o = scan_valid;
    id_o    = scan_id;
    if (lock_q) begin
      valid_o = req_i[lock_id_q];
      id_o    = lock_id_q;
    end
  end

  // One-hot view of the grant
  always_comb begin
    gnt_o = '0;
    for (int i = 0; i < NumReq; i++) begin
      gnt_o[i] = valid_o & (id_o == IdWidth'(i));
    end
  end

  assign nxt_ptr = IdWidth'((32'(id_o) + 32'd1) % NumReq);

  // Pointer advances past the winner on issue; lock tracks stalls
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q  <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else if (flush_i) begin
      lock_q    <= 1'b0;
    end else if (valid_o && ready_i) begin
      lock_q    <= 1'b0;
      rr_ptr_q  <= nxt_ptr;
    end else if (valid_o) begin
      lock_q    <= 1'b1;
      lock_id_q <= id_o;
    end
  end

  // A locked requester must keep its request up
  a_lock_hold: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (lock_q && !flush_i) |-> req_i[lock_id_q]
  );

endmodule

// File: rtl/fpnew_req_scheduler.sv
// fpnew_req_scheduler: shares one FPU among NumReq requesters.
// Round-robin issue, id-routed responses, per-requester credits.
module fpnew_req_scheduler
  import fpnew_pkg::*;
#(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned MaxOutstanding = 4,
  parameter type         ReqType        = logic,
  parameter type         RspType        = logic,
  localparam int unsigned IdWidth  = id_width(NumReq),
  localparam int unsigned CntWidth = cnt_width(MaxOutstanding)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  ReqType             req_i [NumReq],
  input  logic [NumReq-1:0]  req_valid_i,
  output logic [NumReq-1:0]  req_ready_o,
  output ReqType             fpu_req_o,
  output logic [IdWidth-1:0] fpu_id_o,
  output logic               fpu_valid_o,
  input  logic               fpu_ready_i,
  input  RspType             fpu_rsp_i,
  input  logic [IdWidth-1:0] fpu_rsp_id_i,
  input  logic               fpu_rsp_valid_i,
  output logic               fpu_rsp_ready_o,
  output RspType             rsp_o,
  output logic [NumReq-1:0]  rsp_valid_o,
  input  logic [NumReq-1:0]  rsp_ready_i,
  output logic               busy_o
);

  typedef logic [CntWidth-1:0] cnt_t;
  localparam cnt_t CntMax = cnt_t'(MaxOutstanding);

  cnt_t               cnt_q  [NumReq];
  cnt_op_e            cnt_op [NumReq];
  logic [NumReq-1:0]  elig;
  logic [NumReq-1:0]  gnt_oh;
  logic [NumReq-1:0]  issue_oh;
  logic [NumReq-1:0]  rsp_sel;
  logic [NumReq-1:0]  rsp_hs;
  logic [IdWidth-1:0] gnt_id;
  logic               arb_valid;
  logic               live;
  logic               issue_hs;
  logic               cnt_any;

  assign live = rst_ni & ~flush_i;

  // Requesters out of credit drop out of arbitration
  always_comb begin
    elig = '0;
    for (int i = 0; i < NumReq; i++) begin
      elig[i] = req_valid_i[i] & (cnt_q[i] != CntMax);
    end
  end

  fpnew_sched_rr_arb #(
    .NumReq (NumReq)
  ) u_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .req_i   (elig),
    .ready_i (fpu_ready_i),
    .valid_o (arb_valid),
    .gnt_o   (gnt_oh),
    .id_o    (gnt_id)
  );

  assign fpu_valid_o = arb_valid & live;
  assign fpu_req_o   = req_i[gnt_id];
  assign fpu_id_o    = gnt_id;
  assign req_ready_o = gnt_oh & {NumReq{fpu_ready_i & live}};
  assign issue_hs    = fpu_valid_o & fpu_ready_i;
  assign issue_oh    = gnt_oh & {NumReq{issue_hs}};

  // Decode the returned index into a one-hot select
  always_comb begin
    rsp_sel = '0;
    for (int k = 0; k < NumReq; k++) begin
      rsp_sel[k] = (fpu_rsp_id_i == IdWidth'(k));
    end
  end

  assign rsp_o           = fpu_rsp_i;
  assign rsp_valid_o     = rsp_sel & {NumReq{fpu_rsp_valid_i & live}};
  assign fpu_rsp_ready_o = |(rsp_sel & rsp_ready_i);
  assign rsp_hs          = rsp_valid_o & rsp_ready_i;

  // Pick each credit counter's update; flush wins
  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      cnt_op[i] = CNT_HOLD;
      unique case (1'b1)
        flush_i:                  cnt_op[i] = CNT_CLR;
        issue_oh[i] & ~rsp_hs[i]: cnt_op[i] = CNT_INC;
        rsp_hs[i] & ~issue_oh[i]: cnt_op[i] = CNT_DEC;
        default:                  cnt_op[i] = CNT_HOLD;
      endcase
    end
  end

  // Saturating credit counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumReq; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumReq; i++) begin
        unique case (cnt_op[i])
          CNT_CLR: cnt_q[i] <= '0;
          CNT_INC: if (cnt_q[i] != CntMax) cnt_q[i] <= cnt_q[i] + 1'b1;
          CNT_DEC: if (cnt_q[i] != '0) cnt_q[i] <= cnt_q[i] - 1'b1;
          default: cnt_q[i] <= cnt_q[i];
        endcase
      end
    end
  end

  // Any credit outstanding keeps the scheduler busy
  always_comb begin
    cnt_any = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      cnt_any = cnt_any | (cnt_q[i] != '0);
    end
  end

  assign busy_o = fpu_valid_o | cnt_any;

  // Responses must name a real requester
  a_rsp_id_range: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    fpu_rsp_valid_i |-> (32'(fpu_rsp_id_i) < NumReq)
  );

  // Responses must match an outstanding credit
  a_rsp_credit: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (fpu_rsp_valid_i && fpu_rsp_ready_o && !flush_i)
      |-> (cnt_q[fpu_rsp_id_i] != '0)
  );

endmodule

// File: tb/tb_fpnew_req_scheduler.sv
// tb_fpnew_req_scheduler: directed bench for the FPU request scheduler.
// Four requesters, two credits each, 8-bit payloads.
module tb_fpnew_req_scheduler;

  localparam int NR = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [7:0] req [NR];
  logic [3:0] req_valid;
  logic [3:0] req_ready;
  logic [7:0] fpu_req;
  logic [1:0] fpu_id;
  logic       fpu_valid;
  logic       fpu_ready;
  logic [7:0] fpu_rsp;
  logic [1:0] fpu_rsp_id;
  logic       fpu_rsp_valid;
  logic       fpu_rsp_ready;
  logic [7:0] rsp;
  logic [3:0] rsp_valid;
  logic [3:0] rsp_ready;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int prev     = 0;

  always #5 clk = ~clk;

  fpnew_req_scheduler #(
    .NumReq         (4),
    .MaxOutstanding (2),
    .ReqType        (logic [7:0]),
    .RspType        (logic [7:0])
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .flush_i         (flush),
    .req_i           (req),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .fpu_req_o       (fpu_req),
    .fpu_id_o        (fpu_id),
    .fpu_valid_o     (fpu_valid),
    .fpu_ready_i     (fpu_ready),
    .fpu_rsp_i       (fpu_rsp),
    .fpu_rsp_id_i    (fpu_rsp_id),
    .fpu_rsp_valid_i (fpu_rsp_valid),
    .fpu_rsp_ready_o (fpu_rsp_ready),
    .rsp_o           (rsp),
    .rsp_valid_o     (rsp_valid),
    .rsp_ready_i     (rsp_ready),
    .busy_o          (busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush         = 1'b0;
    req_valid     = 4'b0000;
    fpu_ready     = 1'b0;
    fpu_rsp       = 8'h00;
    fpu_rsp_id    = 2'd0;
    fpu_rsp_valid = 1'b0;
    rsp_ready     = 4'b0000;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    for (int i = 0; i < NR; i++) req[i] = 8'(8'hA0 + i);
    #2;
    chk("rst_fpu_valid", 32'(fpu_valid), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Test 1: all valid, immediate responses -> 0,1,2,3,0,1
    req_valid = 4'b1111;
    fpu_ready = 1'b1;
    rsp_ready = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      fpu_rsp_valid = (k > 0);
      fpu_rsp_id    = 2'(prev);
      fpu_rsp       = 8'(8'h50 + prev);
      #1;
      chk("t1_valid", 32'(fpu_valid), 32'd1);
      chk("t1_id", 32'(fpu_id), 32'(k % 4));
      chk("t1_req", 32'(fpu_req), 32'(8'hA0 + k % 4));
      chk("t1_ready", 32'(req_ready), 32'(1 << (k % 4)));
      chk("t1_rspv", 32'(rsp_valid), (k > 0) ? 32'(1 << prev) : 32'd0);
      prev = k % 4;
      tick();
    end
    req_valid     = 4'b0000;
    fpu_rsp_valid = 1'b1;
    fpu_rsp_id    = 2'(prev);
    #1;
    chk("t1_drain_valid", 32'(fpu_valid), 32'd0);
    tick();
    fpu_rsp_valid = 1'b0;
    #1;
    chk("t1_busy", 32'(busy), 32'd0);

    // Test 2: requester 2 stalled three cycles, lock holds grant
    req[2]    = 8'hC2;
    req_valid = 4'b0100;
    fpu_ready = 1'b0;
    #1;
    chk("t2_id_a", 32'(fpu_id), 32'd2);
    chk("t2_ready_a", 32'(req_ready), 32'd0);
    chk("t2_busy", 32'(busy), 32'd1);
    tick();
    #1;
    chk("t2_id_b", 32'(fpu_id), 32'd2);
    tick();
    req_valid = 4'b0101;
    #1;
    chk("t2_id_c", 32'(fpu_id), 32'd2);
    chk("t2_req_c", 32'(fpu_req), 32'hC2);
    tick();
    fpu_ready = 1'b1;
    #1;
    chk("t2_id_d", 32'(fpu_id), 32'd2);
    chk("t2_ready_d", 32'(req_ready), 32'b0100);
    tick();
    #1;
    chk("t2_next_id", 32'(fpu_id), 32'd0);
    chk("t2_next_ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid     = 4'b0000;
    rsp_ready     = 4'b1111;
    fpu_rsp_valid = 1'b1;
    fpu_rsp_id    = 2'd2;
    tick();
    fpu_rsp_valid = 1'b0;

    // Test 4: issue and response for requester 0 together
    req_valid     = 4'b0001;
    fpu_rsp_valid = 1'b1;
    fpu_rsp_id    = 2'd0;
    #1;
    chk("t4_cnt_before", 32'(dut.cnt_q[0]), 32'd1);
    chk("t4_rspv", 32'(rsp_valid), 32'b0001);
    chk("t4_issue", 32'(req_ready), 32'b0001);
    tick();
    chk("t4_cnt_after", 32'(dut.cnt_q[0]), 32'd1);
    req_valid = 4'b0000;
    tick();
    fpu_rsp_valid = 1'b0;
    #1;
    chk("t4_cnt_drain", 32'(dut.cnt_q[0]), 32'd0);

    // Test 3: requester 1 runs out of credit, one return reopens it
    req_valid = 4'b0010;
    #1;
    chk("t3_id_a", 32'(fpu_id), 32'd1);
    tick();
    #1;
    chk("t3_ready_b", 32'(req_ready), 32'b0010);
    tick();
    #1;
    chk("t3_cnt_full", 32'(dut.cnt_q[1]), 32'd2);
    chk("t3_blk_valid", 32'(fpu_valid), 32'd0);
    chk("t3_blk_ready", 32'(req_ready), 32'd0);
    tick();
    fpu_rsp_valid = 1'b1;
    fpu_rsp_id    = 2'd1;
    #1;
    chk("t3_rsp_cycle_valid", 32'(fpu_valid), 32'd0);
    chk("t3_rspv", 32'(rsp_valid), 32'b0010);
    tick();
    fpu_rsp_valid = 1'b0;
    #1;
    chk("t3_reissue_id", 32'(fpu_id), 32'd1);
    chk("t3_reissue_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("t3_cnt_again", 32'(dut.cnt_q[1]), 32'd2);

    // Test 5: response for requester 3 waits on its own ready
    req_valid = 4'b1000;
    #1;
    chk("t5_issue_id", 32'(fpu_id), 32'd3);
    tick();
    req_valid     = 4'b0000;
    rsp_ready     = 4'b0111;
    fpu_rsp_valid = 1'b1;
    fpu_rsp_id    = 2'd3;
    fpu_rsp       = 8'h3C;
    #1;
    chk("t5_rdy_a", 32'(fpu_rsp_ready), 32'd0);
    chk("t5_rspv", 32'(rsp_valid), 32'b1000);
    chk("t5_rsp", 32'(rsp), 32'h3C);
    tick();
    #1;
    chk("t5_rdy_b", 32'(fpu_rsp_ready), 32'd0);
    chk("t5_cnt_hold", 32'(dut.cnt_q[3]), 32'd1);
    tick();
    rsp_ready = 4'b1000;
    #1;
    chk("t5_rdy_c", 32'(fpu_rsp_ready), 32'd1);
    tick();
    fpu_rsp_valid = 1'b0;
    rsp_ready     = 4'b1111;
    #1;
    chk("t5_cnt_done", 32'(dut.cnt_q[3]), 32'd0);

    // Test 6: build counts {1,2,0,1}, lock requester 0, flush
    req_valid = 4'b1001;
    fpu_ready = 1'b1;
    #1;
    chk("t6_first", 32'(fpu_id), 32'd0);
    tick();
    #1;
    chk("t6_second", 32'(fpu_id), 32'd3);
    tick();
    req_valid = 4'b0001;
    fpu_ready = 1'b0;
    #1;
    chk("t6_cnt0", 32'(dut.cnt_q[0]), 32'd1);
    chk("t6_cnt1", 32'(dut.cnt_q[1]), 32'd2);
    chk("t6_cnt2", 32'(dut.cnt_q[2]), 32'd0);
    chk("t6_cnt3", 32'(dut.cnt_q[3]), 32'd1);
    tick();
    chk("t6_locked", 32'(dut.u_arb.lock_q), 32'd1);
    flush         = 1'b1;
    fpu_ready     = 1'b1;
    fpu_rsp_valid = 1'b1;
    fpu_rsp_id    = 2'd1;
    #1;
    chk("t6_flush_valid", 32'(fpu_valid), 32'd0);
    chk("t6_flush_rspv", 32'(rsp_valid), 32'd0);
    chk("t6_flush_ready", 32'(req_ready), 32'd0);
    tick();
    idle();
    #1;
    chk("t6_cnt0_clr", 32'(dut.cnt_q[0]), 32'd0);
    chk("t6_cnt1_clr", 32'(dut.cnt_q[1]), 32'd0);
    chk("t6_cnt3_clr", 32'(dut.cnt_q[3]), 32'd0);
    chk("t6_lock_clr", 32'(dut.u_arb.lock_q), 32'd0);
    chk("t6_rr_hold", 32'(dut.u_arb.rr_ptr_q), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);

    // Reset while locked drops the outputs at once
    req_valid = 4'b0010;
    #1;
    chk("t6_relock_id", 32'(fpu_id), 32'd1);
    tick();
    chk("t6_relocked", 32'(dut.u_arb.lock_q), 32'd1);
    fpu_ready     = 1'b1;
    fpu_rsp_valid = 1'b1;
    fpu_rsp_id    = 2'd1;
    rsp_ready     = 4'b1111;
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(fpu_valid), 32'd0);
    chk("t6_rst_ready", 32'(req_ready), 32'd0);
    chk("t6_rst_rspv", 32'(rsp_valid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    idle();
    tick();
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
